core_sequencer: RTL

//  Multi-cycle instruction sequencer for the 16-bit core. Fetches each instruction over a req/ack port,

---
 rtl/core_sequencer_if.sv | 22 ++
 rtl/core_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer_if.sv
// rtl/core_sequencer_if.sv - fetch and data-memory handshake bundle for core_sequencer
interface core_seq_if #(
   parameter int unsigned PC_W = 16
);
   logic            if_req;
   logic [PC_W-1:0] if_addr;
   logic            if_ack;
   logic [15:0]     if_data;
   logic            dm_req;
   logic            dm_we;
   logic            dm_ack;

   modport master (
      output if_req, if_addr, dm_req, dm_we,
      input  if_ack, if_data, dm_ack
   );

   modport slave (
      input  if_req, if_addr, dm_req, dm_we,
      output if_ack, if_data, dm_ack
   );
endinterface

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - PC-driven multi-cycle instruction sequencer with ack-timeout fault
module core_sequencer #(
   parameter int unsigned     PC_W        = 16,
   parameter logic [PC_W-1:0] RESET_PC    = '0,
   parameter int unsigned     ACK_TIMEOUT = 15
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            run,
   core_seq_if.master      bus,
   output logic [15:0]     instr,
   output logic            en_s,
   output logic            en_c,
   output logic [7:0]      en_reg,
   output logic [PC_W-1:0] pc,
   output logic            done,
   output logic            illegal,
   output logic            fault
);
   localparam int unsigned   TW         = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_RETIRE, S_HALT
   } state_t;

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [15:0]     instr_q, instr_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic            if_req_q, if_req_d;
   logic            en_s_q, en_s_d;
   logic            en_c_q, en_c_d;
   logic [7:0]      en_reg_q, en_reg_d;
   logic            dm_req_q, dm_req_d;
   logic            dm_we_q, dm_we_d;
   logic            done_q, done_d;
   logic            illegal_q, illegal_d;
   logic            fault_q, fault_d;
   logic            timed_out;

   // timer_q holds the number of already-expired wait cycles, so the last allowed cycle is ACK_TIMEOUT-1
   assign timed_out = (timer_q == TIMER_LAST);

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      timer_d   = '0;
      fault_d   = fault_q;
      if_req_d  = 1'b0;
      en_s_d    = 1'b0;
      en_c_d    = 1'b0;
      en_reg_d  = '0;
      dm_req_d  = 1'b0;
      dm_we_d   = 1'b0;
      done_d    = 1'b0;
      illegal_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (run) begin
               state_d  = S_FETCH;
               if_req_d = 1'b1;
            end
         end
         S_FETCH: begin
            if (bus.if_ack) begin
               instr_d = bus.if_data;
               pc_d    = pc_q + PC_W'(1);
               state_d = S_DECODE;
               en_s_d  = 1'b1;
            end else if (timed_out) begin
               fault_d = 1'b1;
               state_d = S_HALT;
            end else begin
               if_req_d = 1'b1;
               timer_d  = timer_q + TW'(1);
            end
         end
         S_DECODE: begin
            case (instr_q[1:0])
               2'd2: begin
                  state_d   = S_RETIRE;
                  done_d    = 1'b1;
                  illegal_d = 1'b1;
               end
               2'd3: begin
                  state_d  = S_MEM;
                  dm_req_d = 1'b1;
                  dm_we_d  = instr_q[2];
               end
               default: begin
                  state_d = S_EXEC;
                  en_c_d  = 1'b1;
               end
            endcase
         end
         S_EXEC: begin
            state_d  = S_WB;
            en_reg_d = 8'd1 << instr_q[15:13];
         end
         S_WB: begin
            state_d = S_RETIRE;
            done_d  = 1'b1;
         end
         // Loads skip WB: the datapath writes Rx itself when dm_ack arrives
         S_MEM: begin
            if (bus.dm_ack) begin
               state_d = S_RETIRE;
               done_d  = 1'b1;
            end else if (timed_out) begin
               fault_d = 1'b1;
               state_d = S_HALT;
            end else begin
               dm_req_d = 1'b1;
               dm_we_d  = instr_q[2];
               timer_d  = timer_q + TW'(1);
            end
         end
         S_RETIRE: begin
            if (run) begin
               state_d  = S_FETCH;
               if_req_d = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         pc_q      <= RESET_PC;
         instr_q   <= '0;
         timer_q   <= '0;
         if_req_q  <= 1'b0;
         en_s_q    <= 1'b0;
         en_c_q    <= 1'b0;
         en_reg_q  <= '0;
         dm_req_q  <= 1'b0;
         dm_we_q   <= 1'b0;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         timer_q   <= timer_d;
         if_req_q  <= if_req_d;
         en_s_q    <= en_s_d;
         en_c_q    <= en_c_d;
         en_reg_q  <= en_reg_d;
         dm_req_q  <= dm_req_d;
         dm_we_q   <= dm_we_d;
         done_q    <= done_d;
         illegal_q <= illegal_d;
         fault_q   <= fault_d;
      end
   end

   assign bus.if_req  = if_req_q;
   assign bus.if_addr = pc_q;
   assign bus.dm_req  = dm_req_q;
   assign bus.dm_we   = dm_we_q;
   assign instr       = instr_q;
   assign en_s        = en_s_q;
   assign en_c        = en_c_q;
   assign en_reg      = en_reg_q;
   assign pc          = pc_q;
   assign done        = done_q;
   assign illegal     = illegal_q;
   assign fault       = fault_q;
endmodule
